sweep_ram: RTL and testbench
============================

# sweep_ram

Parametrised single-port synchronous RAM with a built-in sequential clear engine and a valid-qualified read path. It replaces the fixed 256x16 store in the datapath. A reset or a `clr` pulse starts a hardware sweep that writes `CLR_VAL` to every location, one per cycle, while `busy` is high. Width, depth and clear value are parameters; an optional output register trades one cycle of latency for timing.

## Interface
- `DATA_W`, 16, data word width in bits (≥1)
- `ADDR_W`, 8, address width; depth is `DEPTH = 2**ADDR_W`
- `CLR_VAL`, 0, `DATA_W`-bit value written to every word by a sweep
- `sysclk`  in  1  single clock; all logic on its rising edge
- `reset_n`  in  1  reset is synchronous and active-low
- `clr`  in  1  one-cycle request to clear the whole array
- `write`  in  1  write strobe
- `rd_en`  in  1  read strobe
- `addr`  in  `ADDR_W`  shared read/write address
- `data_in`  in  `DATA_W`  write data
- `data_out`  out  `DATA_W`  read data, held until the next accepted read
- `rd_valid`  out  1  one-cycle pulse; `data_out` is fresh
- `busy`  out  1  clear sweep in progress; user accesses are dropped

## Operation
- FSM states: `IDLE`, `CLEAR`. Sweep pointer `ptr` is `ADDR_W` bits wide.
- Reset (`reset_n`=0 at an edge):
  - state goes to `CLEAR`; `ptr`=0.
  - Outputs: `busy`=1, `rd_valid`=0, `data_out`=0.
  - No array write occurs while `reset_n` is low.
- `CLEAR` (`reset_n`=1):
  - each cycle writes `mem[ptr] <= CLR_VAL`, then `ptr` increments.
  - When `ptr` = `DEPTH-1` has been written, go to `IDLE` and clear `ptr` to 0.
  - A sweep takes exactly `DEPTH` cycles.
- `IDLE`, `clr`=1: go to `CLEAR` with `ptr`=0. Any `write` or `rd_en` in that same cycle is still accepted.
- `clr` during `CLEAR` is ignored; the sweep does not restart.
- `write` or `rd_en` while `busy`=1 is silently dropped.
  - No array change.
  - `rd_valid` stays 0.
  - `data_out` holds its value.
- `IDLE` write: `mem[addr] <= data_in`.
- `IDLE` read: `data_out <= mem[addr]` and `rd_valid` pulses.
- Read and write to the same address in the same cycle: read-first. `data_out` returns the old contents; the new data is visible on the next read.
- `data_out` changes only on an accepted read or on reset.
- Address range is full (`DEPTH = 2**ADDR_W`), so no out-of-range case exists.

## Timing
- `busy` is registered:
  - high the cycle after a reset edge or an accepted `clr`;
  - falls the cycle after the last sweep write.
- Read latency is 1 cycle: read accepted at edge N → `data_out` and `rd_valid` valid after edge N+1.
- Back-to-back reads are supported at one per cycle; `rd_valid` is high on consecutive cycles.
- Write completes at the accepting edge. A read issued at the next cycle returns the new data.
- Reset mid-sweep restarts the sweep from `ptr`=0. Reset mid-read kills the pending `rd_valid`.
- From release of `reset_n`, first access is accepted after `DEPTH` cycles.

## Configuration
- `SWEEP_RAM_OUTREG_EN` defined:
  - adds one pipeline register after the array read;
  - read latency is 2 cycles;
  - `rd_valid` is delayed to match;
  - reset clears the extra stage (data 0, valid 0).
- `SWEEP_RAM_OUTREG_EN` undefined: latency is 1 cycle as above.
- Sweep behaviour is identical in both builds.

## Structure
- Shared package `sweep_ram_pkg`:
  - FSM state typedef (`IDLE`, `CLEAR`);
  - default parameter constants `DATA_W_DEF`, `ADDR_W_DEF`.
- Sub-module `ram_core`:
  - plain array with one write port (`we`, `waddr`, `wdata`) and one registered read port;
  - no reset on the array;
  - the top level muxes the sweep pointer and `CLR_VAL` onto the write port during `CLEAR`.
- FSM, pointer, valid pipeline and the optional output stage live in the top level.

## Test plan
- Reset, `DEPTH`=256, `CLR_VAL`=16'hA5A5 → `busy`=1 for exactly 256 cycles after release; reading addresses 0, 128 and 255 returns 16'hA5A5.
- Write 16'h1234 @ 0x10, then read 0x10 the next cycle → `data_out`=16'h1234 and a single `rd_valid` pulse, 1 cycle after the read (2 cycles with `SWEEP_RAM_OUTREG_EN`).
- Write 16'hBEEF and read @ 0x20 in the same cycle, with old contents 16'h0001 → `data_out`=16'h0001; the following read returns 16'hBEEF.
- `clr` pulse in `IDLE` together with a write of 16'h5555 @ 0x05 → write accepted, then the sweep runs; after `busy` falls, reading 0x05 returns `CLR_VAL`.
- Writes and reads issued during a sweep, plus a second `clr` mid-sweep → all dropped: no `rd_valid`, `data_out` unchanged, sweep length stays `DEPTH` cycles.
- Assert `reset_n` low at sweep cycle 100, release 3 cycles later → `busy` held; a full `DEPTH`-cycle sweep restarts from 0.

Source files
------------

// File: rtl/sweep_ram_pkg.sv
// Shared types and default sizes for the sweep_ram clearable RAM.
package sweep_ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/sweep_ram_if.sv
// User-side access bus of sweep_ram: strobes, address, data and status.
interface sweep_ram_if
  import sweep_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              clr;
  logic              write;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output clr, write, rd_en, addr, data_in,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  clr, write, rd_en, addr, data_in,
    output data_out, rd_valid, busy
  );

endinterface

// File: rtl/sweep_ram_core.sv
// ram_core: plain single-write-port array with a registered, read-first read port.
module ram_core
  import sweep_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // NOTE: the array is deliberately left without reset so it maps onto RAM macros;
  // the clear sweep in the parent initialises the contents instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reading the pre-edge array contents gives read-first on a same-address write.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sweep_ram.sv
// sweep_ram: single-port RAM with a hardware clear sweep and valid-qualified reads.
// Define SWEEP_RAM_OUTREG_EN to add an output register (read latency 2 instead of 1).
module sweep_ram
  import sweep_ram_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic       sysclk,
  input logic       reset_n,
  sweep_ram_if.slave bus
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_valid_q, rd_valid_d;

  logic              idle;
  logic              acc_wr;
  logic              acc_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign idle   = (state_q == IDLE);
  assign acc_wr = idle && bus.write;
  assign acc_rd = idle && bus.rd_en;

  // NOTE: every output is given a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = acc_rd;
    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // The sweep owns the write port while clearing; nothing is written in reset.
  always_comb begin
    mem_we    = reset_n && (!idle || acc_wr);
    mem_waddr = idle ? bus.addr : ptr_q;
    mem_wdata = idle ? bus.data_in : CLR_VAL;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (sysclk),
    .rst_n (reset_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (acc_rd),
    .raddr (bus.addr),
    .rdata (mem_rdata)
  );

`ifdef SWEEP_RAM_OUTREG_EN
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_out_q, valid_out_d;

  // The extra stage only captures fresh read data, so data_out still holds between reads.
  always_comb begin
    dout_d      = rd_valid_q ? mem_rdata : dout_q;
    valid_out_d = rd_valid_q;
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      dout_q      <= '0;
      valid_out_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.rd_valid = valid_out_q;
`else
  assign bus.data_out = mem_rdata;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.busy = (state_q == CLEAR);

endmodule

// File: tb/tb_sweep_ram.sv
// Self-checking bench for sweep_ram against a behavioural array/queue model.
module tb_sweep_ram;

  localparam int          DW    = 16;
  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam logic [15:0] CLR   = 16'hA5A5;
`ifdef SWEEP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } rd_t;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;

  always #5 sysclk = ~sysclk;

  sweep_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sweep_ram #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .CLR_VAL (CLR)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: array contents, remaining busy cycles, in-flight reads.
  logic [15:0] mem_m [DEPTH];
  int          busy_left = DEPTH;
  rd_t         pipe[$];
  logic        exp_valid = 1'b0;
  logic [15:0] exp_dout  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step(input logic c, input logic w, input logic r,
                      input logic [7:0] a, input logic [15:0] d);
    rd_t e;
    rd_t cur;
    bus.clr     = c;
    bus.write   = w;
    bus.rd_en   = r;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge sysclk);
    e = '0;
    if (!reset_n) begin
      busy_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = CLR;
      pipe.delete();
      exp_valid = 1'b0;
      exp_dout  = '0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        e.v = r;
        e.d = mem_m[a];
        if (w) mem_m[a] = d;
        if (c) begin
          busy_left = DEPTH;
          foreach (mem_m[i]) mem_m[i] = CLR;
        end
      end
      pipe.push_back(e);
      cur = '0;
      if (pipe.size() >= LAT) cur = pipe.pop_front();
      exp_valid = cur.v;
      if (cur.v) exp_dout = cur.d;
    end
    @(negedge sysclk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  // Issues a read and advances to the cycle where its data is due.
  task automatic do_read(input logic [7:0] a);
    step(1'b0, 1'b0, 1'b1, a, 16'h0000);
    idle(LAT - 1);
  endtask

  // Counts busy-high samples, bounded so a stuck busy cannot hang the run.
  task automatic measure_sweep(output int cnt);
    cnt = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (bus.busy !== 1'b1) break;
      cnt++;
      idle(1);
    end
  endtask

  task automatic test_reset;
    int          cnt;
    logic [7:0]  probe [3];
    reset_n = 1'b0;
    idle(3);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rd_valid); end
    n_tests++;
    if (bus.data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", bus.data_out); end
    reset_n = 1'b1;
    measure_sweep(cnt);
    n_tests++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL reset_sweep_len: got %0d expected %0d", cnt, DEPTH); end
    probe[0] = 8'h00;
    probe[1] = 8'h80;
    probe[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      do_read(probe[k]);
      n_tests++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== CLR) begin
        n_fail++;
        $display("FAIL reset_readback @%h: got valid=%b data=%h expected valid=1 data=%h",
                 probe[k], bus.rd_valid, bus.data_out, CLR);
      end
    end
    idle(2);
  endtask

  task automatic test_write_read;
    step(1'b0, 1'b1, 1'b0, 8'h10, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 8'h10, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) idle(1);
      n_tests++;
      if (bus.rd_valid !== (k == LAT)) begin
        n_fail++;
        $display("FAIL wr_rd_valid cycle %0d: got %b expected %b", k, bus.rd_valid, (k == LAT));
      end
      if (k >= LAT) begin
        n_tests++;
        if (bus.data_out !== 16'h1234) begin
          n_fail++;
          $display("FAIL wr_rd_data cycle %0d: got %h expected 1234", k, bus.data_out);
        end
      end
    end
  endtask

  task automatic test_read_first;
    step(1'b0, 1'b1, 1'b0, 8'h20, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    idle(LAT - 1);
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL read_first_old: got valid=%b data=%h expected valid=1 data=0001", bus.rd_valid, bus.data_out);
    end
    do_read(8'h20);
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL read_first_new: got valid=%b data=%h expected valid=1 data=beef", bus.rd_valid, bus.data_out);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [3];
    int          j;
    for (int k = 0; k < 3; k++) begin
      vals[k] = 16'($urandom);
      step(1'b0, 1'b1, 1'b0, 8'(8'h40 + k), vals[k]);
    end
    for (int k = 0; k < LAT + 3; k++) begin
      step(1'b0, 1'b0, (k < 3), 8'(8'h40 + k), 16'h0000);
      j = k - (LAT - 1);
      if (j >= 0 && j < 3) begin
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== vals[j]) begin
          n_fail++;
          $display("FAIL b2b read %0d: got valid=%b data=%h expected valid=1 data=%h",
                   j, bus.rd_valid, bus.data_out, vals[j]);
        end
      end else if (j >= 3) begin
        n_tests++;
        if (bus.rd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b trailing valid: got %b expected 0", bus.rd_valid);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_clr_with_write;
    int cnt;
    step(1'b0, 1'b1, 1'b0, 8'h05, 16'h1111);
    step(1'b1, 1'b1, 1'b1, 8'h05, 16'h5555);
    cnt = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (i == LAT - 1) begin
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h1111) begin
          n_fail++;
          $display("FAIL clr_cycle_read: got valid=%b data=%h expected valid=1 data=1111",
                   bus.rd_valid, bus.data_out);
        end
      end
      if (bus.busy !== 1'b1) break;
      cnt++;
      idle(1);
    end
    n_tests++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL clr_sweep_len: got %0d expected %0d", cnt, DEPTH); end
    do_read(8'h05);
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.data_out !== CLR) begin
      n_fail++;
      $display("FAIL clr_readback: got valid=%b data=%h expected valid=1 data=%h", bus.rd_valid, bus.data_out, CLR);
    end
    idle(2);
  endtask

  task automatic test_busy_drop;
    int          cnt;
    int          bad_valid;
    int          bad_dout;
    logic [15:0] held;
    idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    held      = bus.data_out;
    cnt       = 0;
    bad_valid = 0;
    bad_dout  = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (bus.busy !== 1'b1) break;
      cnt++;
      if (bus.rd_valid !== 1'b0) bad_valid++;
      if (bus.data_out !== held) bad_dout++;
      step((i == 100), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'(8'h60 + $urandom_range(0, 7)), 16'($urandom));
    end
    n_tests++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL drop_sweep_len: got %0d expected %0d", cnt, DEPTH); end
    n_tests++;
    if (bad_valid != 0) begin n_fail++; $display("FAIL drop_valid: got %0d pulses expected 0", bad_valid); end
    n_tests++;
    if (bad_dout != 0) begin n_fail++; $display("FAIL drop_dout: got %0d changes expected 0", bad_dout); end
    for (int k = 0; k < 8; k++) begin
      do_read(8'(8'h60 + k));
      n_tests++;
      if (bus.data_out !== CLR) begin
        n_fail++;
        $display("FAIL drop_readback @%h: got %h expected %h", 8'(8'h60 + k), bus.data_out, CLR);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_op;
    int cnt;
    step(1'b0, 1'b1, 1'b0, 8'h30, 16'h7777);
    step(1'b0, 1'b0, 1'b1, 8'h30, 16'h0000);
    reset_n = 1'b0;
    idle(1);
    n_tests++;
    if (bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_kill_read: got valid=%b data=%h busy=%b expected valid=0 data=0000 busy=1",
               bus.rd_valid, bus.data_out, bus.busy);
    end
    reset_n = 1'b1;
    idle(100);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_tests++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy %0d: got %b expected 1", k, bus.busy); end
    end
    reset_n = 1'b1;
    measure_sweep(cnt);
    n_tests++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL mid_reset_sweep_len: got %0d expected %0d", cnt, DEPTH); end
    idle(2);
  endtask

  task automatic test_random;
    logic c;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 99) == 0);
      step(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'(8'h80 + $urandom_range(0, 15)), 16'($urandom));
      n_tests++;
      if (bus.rd_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_valid cycle %0d: got %b expected %b", i, bus.rd_valid, exp_valid);
      end
      n_tests++;
      if (bus.data_out !== exp_dout) begin
        n_fail++;
        $display("FAIL rand_dout cycle %0d: got %h expected %h", i, bus.data_out, exp_dout);
      end
      n_tests++;
      if (bus.busy !== (busy_left > 0)) begin
        n_fail++;
        $display("FAIL rand_busy cycle %0d: got %b expected %b", i, bus.busy, (busy_left > 0));
      end
    end
  endtask

  initial begin
    bus.clr     = 1'b0;
    bus.write   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    test_reset;
    test_write_read;
    test_read_first;
    test_back_to_back;
    test_clr_with_write;
    test_busy_drop;
    test_reset_mid_op;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
